// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the IF/MEM backend arbiter: FSM encoding and default bus widths.
package memory_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/memory_arbiter_fetch_buffer.sv
// Single-entry fetch buffer: remembers the last fetched word so a repeated fetch
// of the same address completes without touching the backend.
module fetch_buffer
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              inval_i,
    input  logic [ADDR_W-1:0] inval_addr_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] fb_addr_q;
    logic [DATA_W-1:0] fb_data_q;
    logic              fb_valid_q;

    // Load and invalidate come from different completion types, so they never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_valid_q <= 1'b0;
        end else if (load_i) begin
            fb_addr_q  <= load_addr_i;
            fb_data_q  <= load_data_i;
            fb_valid_q <= 1'b1;
        end else if (inval_i && (inval_addr_i == fb_addr_q)) begin
            fb_valid_q <= 1'b0;
        end
    end

    assign hit_o   = fb_valid_q && (fb_addr_q == lookup_addr_i);
    assign data_o  = fb_data_q;
    assign valid_o = fb_valid_q;

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port backend between instruction fetch and data access,
// one transaction outstanding, with alternating priority under contention.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_req,
    input  logic [ADDR_W-1:0] IF_addr,
    output logic [DATA_W-1:0] IF_rdata,
    output logic              IF_requireStall,
    input  logic              MEM_req,
    input  logic              MEM_we,
    input  logic [ADDR_W-1:0] MEM_addr,
    input  logic [DATA_W-1:0] MEM_wdata,
    output logic [DATA_W-1:0] MEM_rdata,
    output logic              MEM_requireStall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memReady,
    output logic [1:0]        dbg_state_o,
    output logic              dbg_last_grant_mem_o,
    output logic              dbg_fb_valid_o
);

    arb_state_e        state_q, state_d;
    logic              last_grant_mem_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;

    logic              fb_hit;
    logic [DATA_W-1:0] fb_data;
    logic              fb_valid;
    logic              if_miss;
    logic              grant_if;
    logic              grant_mem;
    logic              busy;
    logic              if_done;
    logic              mem_done;

    // Requester inputs only matter in IDLE; while busy they cannot start or alter anything.
    assign if_miss   = IF_req && !fb_hit;
    assign grant_mem = (state_q == ST_IDLE) && MEM_req && (!if_miss || !last_grant_mem_q);
    assign grant_if  = (state_q == ST_IDLE) && if_miss && (!MEM_req || last_grant_mem_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_d = ST_MEM_BUSY;
                end else if (grant_if) begin
                    state_d = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY:  if (memReady) state_d = ST_IDLE;
            ST_MEM_BUSY: if (memReady) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        if_done  = (state_q == ST_IF_BUSY) && memReady;
        mem_done = (state_q == ST_MEM_BUSY) && memReady;
    end

    // Backend command is captured at grant and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_mem_q <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_we_q         <= 1'b0;
        end else if (grant_mem) begin
            last_grant_mem_q <= 1'b1;
            mem_addr_q       <= MEM_addr;
            mem_wdata_q      <= MEM_wdata;
            mem_we_q         <= MEM_we;
        end else if (grant_if) begin
            last_grant_mem_q <= 1'b0;
            mem_addr_q       <= IF_addr;
            mem_wdata_q      <= '0;
            mem_we_q         <= 1'b0;
        end
    end

    fetch_buffer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (if_done),
        .load_addr_i  (mem_addr_q),
        .load_data_i  (memRData),
        .inval_i      (mem_done && mem_we_q),
        .inval_addr_i (mem_addr_q),
        .lookup_addr_i(IF_addr),
        .hit_o        (fb_hit),
        .data_o       (fb_data),
        .valid_o      (fb_valid)
    );

    // Everything visible is forced low while reset is asserted, even mid-transaction.
    always_comb begin
        memReq           = !rst && busy;
        memWe            = !rst && mem_we_q;
        memAddr          = rst ? '0 : mem_addr_q;
        memWData         = rst ? '0 : mem_wdata_q;
        MEM_requireStall = !rst && MEM_req && !mem_done;
        IF_requireStall  = !rst && IF_req && !fb_hit && !if_done;
        MEM_rdata        = (!rst && mem_done && MEM_req) ? memRData : '0;
        if (rst) begin
            IF_rdata = '0;
        end else if (if_done) begin
            IF_rdata = memRData;
        end else if (fb_hit) begin
            IF_rdata = fb_data;
        end else begin
            IF_rdata = '0;
        end
        dbg_state_o          = rst ? 2'd0 : state_q;
        dbg_last_grant_mem_o = !rst && last_grant_mem_q;
        dbg_fb_valid_o       = !rst && fb_valid;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: miss/hit, contention, write invalidation,
// flush and mid-transaction reset, all with hand-computed expectations.
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IF   = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          IF_req;
    logic [AW-1:0] IF_addr;
    logic [DW-1:0] IF_rdata;
    logic          IF_requireStall;
    logic          MEM_req;
    logic          MEM_we;
    logic [AW-1:0] MEM_addr;
    logic [DW-1:0] MEM_wdata;
    logic [DW-1:0] MEM_rdata;
    logic          MEM_requireStall;
    logic          memReq;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic [DW-1:0] memRData;
    logic          memReady;
    logic [1:0]    dbg_state;
    logic          dbg_lgm;
    logic          dbg_fbv;

    int n_checks = 0;
    int n_errors = 0;
    int stalls;

    always #5 clk = ~clk;

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .IF_req              (IF_req),
        .IF_addr             (IF_addr),
        .IF_rdata            (IF_rdata),
        .IF_requireStall     (IF_requireStall),
        .MEM_req             (MEM_req),
        .MEM_we              (MEM_we),
        .MEM_addr            (MEM_addr),
        .MEM_wdata           (MEM_wdata),
        .MEM_rdata           (MEM_rdata),
        .MEM_requireStall    (MEM_requireStall),
        .memReq              (memReq),
        .memWe               (memWe),
        .memAddr             (memAddr),
        .memWData            (memWData),
        .memRData            (memRData),
        .memReady            (memReady),
        .dbg_state_o         (dbg_state),
        .dbg_last_grant_mem_o(dbg_lgm),
        .dbg_fb_valid_o      (dbg_fbv)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        IF_req    = 1'b0;
        IF_addr   = '0;
        MEM_req   = 1'b0;
        MEM_we    = 1'b0;
        MEM_addr  = '0;
        MEM_wdata = '0;
        memReady  = 1'b0;
        memRData  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_memReq"}, memReq, 0);
        check({tag, "_memWe"}, memWe, 0);
        check({tag, "_memAddr"}, memAddr, 0);
        check({tag, "_memWData"}, memWData, 0);
        check({tag, "_if_stall"}, IF_requireStall, 0);
        check({tag, "_mem_stall"}, MEM_requireStall, 0);
        check({tag, "_if_rdata"}, IF_rdata, 0);
        check({tag, "_mem_rdata"}, MEM_rdata, 0);
    endtask

    initial begin
        // Reset with every requester input active: outputs must stay low.
        rst       = 1'b1;
        IF_req    = 1'b1;
        IF_addr   = 32'h100;
        MEM_req   = 1'b1;
        MEM_we    = 1'b1;
        MEM_addr  = 32'h80;
        MEM_wdata = 32'h1234;
        memReady  = 1'b1;
        memRData  = 32'hFFFF_FFFF;
        #1;
        check_all_zero("rst_pre_edge");
        tick();
        tick();
        check_all_zero("rst_held");
        rst = 1'b0;
        idle_inputs();
        settle();
        check("rst_state", dbg_state, S_IDLE);
        check("rst_lgm", dbg_lgm, 0);
        check("rst_fbv", dbg_fbv, 0);
        check_all_zero("rst_after");

        // IF miss on 0x100: three stall cycles, data on completion, then a hit.
        stalls  = 0;
        IF_req  = 1'b1;
        IF_addr = 32'h100;
        settle();
        stalls += int'(IF_requireStall);
        check("miss_t0_memReq", memReq, 0);
        tick();
        stalls += int'(IF_requireStall);
        check("miss_t1_state", dbg_state, S_IF);
        check("miss_t1_memReq", memReq, 1);
        check("miss_t1_memAddr", memAddr, 32'h100);
        check("miss_t1_memWe", memWe, 0);
        check("miss_t1_lgm", dbg_lgm, 0);
        tick();
        IF_addr = 32'h300;
        settle();
        stalls += int'(IF_requireStall);
        check("miss_t2_addr_hold", memAddr, 32'h100);
        tick();
        IF_addr  = 32'h100;
        memReady = 1'b1;
        memRData = 32'hDEAD_BEEF;
        settle();
        stalls += int'(IF_requireStall);
        check("miss_done_stall", IF_requireStall, 0);
        check("miss_done_rdata", IF_rdata, 32'hDEAD_BEEF);
        check("miss_done_mem_rdata", MEM_rdata, 0);
        check("miss_stall_count", stalls, 3);
        tick();
        memReady = 1'b0;
        memRData = 32'h1234_5678;
        settle();
        check("hit_state", dbg_state, S_IDLE);
        check("hit_fbv", dbg_fbv, 1);
        check("hit_stall", IF_requireStall, 0);
        check("hit_rdata", IF_rdata, 32'hDEAD_BEEF);
        check("hit_memReq", memReq, 0);
        // Stray memReady in IDLE changes nothing.
        memReady = 1'b1;
        tick();
        memReady = 1'b0;
        settle();
        check("stray_ready_state", dbg_state, S_IDLE);
        check("stray_ready_memReq", memReq, 0);
        check("stray_ready_hit", IF_rdata, 32'hDEAD_BEEF);

        // Contention right after reset: MEM first, then IF, priority alternates.
        do_reset();
        IF_req   = 1'b1;
        IF_addr  = 32'h40;
        MEM_req  = 1'b1;
        MEM_addr = 32'h80;
        settle();
        check("cont_t0_if_stall", IF_requireStall, 1);
        check("cont_t0_mem_stall", MEM_requireStall, 1);
        tick();
        memReady = 1'b1;
        memRData = 32'hAAAA_5555;
        settle();
        check("cont_mem_state", dbg_state, S_MEM);
        check("cont_mem_addr", memAddr, 32'h80);
        check("cont_mem_lgm", dbg_lgm, 1);
        check("cont_mem_rdata", MEM_rdata, 32'hAAAA_5555);
        check("cont_mem_stall", MEM_requireStall, 0);
        check("cont_mem_if_stall", IF_requireStall, 1);
        check("cont_mem_if_rdata", IF_rdata, 0);
        tick();
        memReady  = 1'b0;
        MEM_we    = 1'b1;
        MEM_addr  = 32'h84;
        MEM_wdata = 32'hC0DE;
        settle();
        check("cont_idle_state", dbg_state, S_IDLE);
        tick();
        memReady = 1'b1;
        memRData = 32'h0BAD_F00D;
        settle();
        check("cont_if_state", dbg_state, S_IF);
        check("cont_if_addr", memAddr, 32'h40);
        check("cont_if_we", memWe, 0);
        check("cont_if_lgm", dbg_lgm, 0);
        check("cont_if_rdata", IF_rdata, 32'h0BAD_F00D);
        check("cont_if_stall", IF_requireStall, 0);
        check("cont_if_mem_stall", MEM_requireStall, 1);
        tick();
        memReady = 1'b0;
        memRData = '0;
        settle();
        check("cont_hit_stall", IF_requireStall, 0);
        check("cont_hit_rdata", IF_rdata, 32'h0BAD_F00D);
        IF_req = 1'b0;
        tick();
        memReady = 1'b1;
        settle();
        check("cont_wr_state", dbg_state, S_MEM);
        check("cont_wr_we", memWe, 1);
        check("cont_wr_addr", memAddr, 32'h84);
        check("cont_wr_wdata", memWData, 32'hC0DE);
        check("cont_wr_lgm", dbg_lgm, 1);
        tick();
        idle_inputs();

        // Write invalidation: fill 0x100, write 0x100, refetch must miss.
        IF_req  = 1'b1;
        IF_addr = 32'h100;
        tick();
        memReady = 1'b1;
        memRData = 32'h0000_0111;
        tick();
        idle_inputs();
        settle();
        check("inv_filled_fbv", dbg_fbv, 1);
        MEM_req   = 1'b1;
        MEM_we    = 1'b1;
        MEM_addr  = 32'h100;
        MEM_wdata = 32'h55;
        tick();
        memReady = 1'b1;
        settle();
        check("inv_wr_we", memWe, 1);
        check("inv_wr_wdata", memWData, 32'h55);
        check("inv_wr_fbv_before", dbg_fbv, 1);
        tick();
        idle_inputs();
        settle();
        check("inv_fbv_cleared", dbg_fbv, 0);
        IF_req  = 1'b1;
        IF_addr = 32'h100;
        settle();
        check("inv_refetch_stall", IF_requireStall, 1);
        check("inv_refetch_rdata", IF_rdata, 0);
        tick();
        check("inv_refetch_state", dbg_state, S_IF);
        check("inv_refetch_memReq", memReq, 1);
        memReady = 1'b1;
        memRData = 32'h0000_0222;
        tick();
        idle_inputs();

        // Flush: MEM drops its request mid-transaction.
        MEM_req  = 1'b1;
        MEM_addr = 32'h200;
        tick();
        MEM_req  = 1'b0;
        MEM_addr = 32'h204;
        tick();
        settle();
        check("flush_memReq_held", memReq, 1);
        check("flush_addr_held", memAddr, 32'h200);
        check("flush_state", dbg_state, S_MEM);
        memReady = 1'b1;
        memRData = 32'h77;
        settle();
        check("flush_rdata_discard", MEM_rdata, 0);
        check("flush_stall", MEM_requireStall, 0);
        tick();
        memReady = 1'b0;
        settle();
        check("flush_idle_state", dbg_state, S_IDLE);
        check("flush_idle_memReq", memReq, 0);

        // Reset during IF_BUSY, then a late memReady.
        IF_req  = 1'b1;
        IF_addr = 32'h300;
        tick();
        check("rbusy_state", dbg_state, S_IF);
        rst = 1'b1;
        settle();
        check("rbusy_memReq_in_rst", memReq, 0);
        check("rbusy_stall_in_rst", IF_requireStall, 0);
        tick();
        rst      = 1'b0;
        IF_req   = 1'b0;
        memReady = 1'b1;
        memRData = 32'h99;
        settle();
        check("rbusy_after_state", dbg_state, S_IDLE);
        check("rbusy_after_fbv", dbg_fbv, 0);
        check_all_zero("rbusy_stray");
        tick();
        memReady = 1'b0;
        IF_req   = 1'b1;
        settle();
        check("rbusy_late_state", dbg_state, S_IDLE);
        check("rbusy_late_fbv", dbg_fbv, 0);
        check("rbusy_refetch_stall", IF_requireStall, 1);
        tick();
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
